instruction_cache_assoc: RTL and testbench

//  Parametrised set-associative instruction cache between the fetch stage and the MMU burst port.

---
 rtl/instruction_cache_assoc_if.sv | 31 +++
 rtl/instruction_cache_assoc.sv | 222 ++++++++++++++++++++++
 tb/tb_instruction_cache_assoc.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_cache_assoc_if.sv
// Fetch-side and MMU-burst-side signal bundle for the instruction cache.
// slave = cache side, master = CPU/MMU environment side.
interface instruction_cache_assoc_if;
  logic [31:0] inst_addr;
  logic        pc_changed;
  logic        inv_all;
  logic [31:0] inst_data;
  logic        inst_ok;
  logic [31:0] inst_addr_mmu;
  logic        inst_read_req;
  logic        inst_addr_ok;
  logic [31:0] inst_read_data;
  logic        mmu_valid;
  logic        mmu_last;

  modport slave (
    input  inst_addr, pc_changed, inv_all,
    input  inst_addr_ok, inst_read_data,
    input  mmu_valid, mmu_last,
    output inst_data, inst_ok,
    output inst_addr_mmu, inst_read_req
  );

  modport master (
    output inst_addr, pc_changed, inv_all,
    output inst_addr_ok, inst_read_data,
    output mmu_valid, mmu_last,
    input  inst_data, inst_ok,
    input  inst_addr_mmu, inst_read_req
  );
endinterface

// File: rtl/instruction_cache_assoc.sv
// Set-associative instruction cache with burst refill,
// critical-word forwarding, tree pseudo-LRU and bulk invalidate.
module instruction_cache_assoc #(
  parameter int WAYS       = 2,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 16
) (
  input logic clk,
  input logic rst,
  instruction_cache_assoc_if.slave bus
);

  localparam int IB = $clog2(SETS);
  localparam int OW = $clog2(LINE_WORDS);
  localparam int OB = OW + 2;
  localparam int TW = 32 - IB - OB;
  localparam int WB = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int PW = (WAYS > 1) ? WAYS - 1 : 1;
  localparam int B1 = (PW > 1) ? 1 : 0;
  localparam int B2 = (PW > 2) ? 2 : 0;

  typedef enum logic [1:0] {
    IDLE, REQ, REFILL, FILL
  } state_t;

  typedef logic [LINE_WORDS-1:0][31:0] line_t;

  state_t state;

  logic [TW-1:0] tag_mem [WAYS][SETS];
  line_t         data_mem [WAYS][SETS];
  logic [WAYS-1:0][SETS-1:0] vld;
  logic [PW-1:0] plru [SETS];

  line_t       line_buf;
  logic [31:0] miss_addr;
  logic [WB-1:0] victim;
  logic [OW-1:0] cnt;
  logic        served;
  logic        abort;
  logic        inv_pend;
  logic        req_q;
  logic [31:0] mmu_addr_q;

  logic [31:0] addr;
  logic [TW-1:0] a_tag;
  logic [IB-1:0] a_idx;
  logic [OW-1:0] a_off;
  logic [TW-1:0] m_tag;
  logic [IB-1:0] m_idx;
  logic [OW-1:0] m_off;

  assign addr  = bus.inst_addr;
  assign a_tag = addr[31:IB+OB];
  assign a_idx = addr[IB+OB-1:OB];
  assign a_off = addr[OB-1:2];
  assign m_tag = miss_addr[31:IB+OB];
  assign m_idx = miss_addr[IB+OB-1:OB];
  assign m_off = miss_addr[OB-1:2];

  // Tree PLRU: a bit points at the half holding the victim.
  function automatic logic [WB-1:0] plru_victim(
    input logic [PW-1:0] b
  );
    logic [WB-1:0] v;
    v = '0;
    if (WAYS == 2)
      v = WB'(b[0]);
    else if (WAYS == 4)
      v = b[0] ? WB'({1'b1, b[B2]})
               : WB'({1'b0, b[B1]});
    return v;
  endfunction

  // Point every bit on the path away from the touched way.
  function automatic logic [PW-1:0] plru_touch(
    input logic [PW-1:0] b,
    input logic [WB-1:0] w
  );
    logic [PW-1:0] nb;
    nb = b;
    if (WAYS == 2) begin
      nb[0] = ~w[0];
    end else if (WAYS == 4) begin
      nb[0] = ~w[WB-1];
      if (w[WB-1])
        nb[B2] = ~w[0];
      else
        nb[B1] = ~w[0];
    end
    return nb;
  endfunction

  logic          hit;
  logic [WB-1:0] hit_way;
  logic [WB-1:0] pick;
  logic          fwd;
  logic          ok_c;
  logic [31:0]   data_c;

  // Tag compare across all ways of the indexed set.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (vld[w][a_idx] && tag_mem[w][a_idx] == a_tag) begin
        hit     = 1'b1;
        hit_way = WB'(w);
      end
    end
  end

  // Victim: lowest invalid way, otherwise the PLRU way.
  always_comb begin
    pick = plru_victim(plru[a_idx]);
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!vld[w][a_idx])
        pick = WB'(w);
    end
  end

  // Critical word is forwarded once, unless the fetch moved on.
  assign fwd = (state == REFILL) && bus.mmu_valid &&
               (cnt == m_off) && !abort && !served &&
               !bus.pc_changed;

  // Same-cycle hit data or forwarded burst beat.
  always_comb begin
    ok_c   = 1'b0;
    data_c = '0;
    if (state == IDLE && hit) begin
      ok_c   = 1'b1;
      data_c = data_mem[hit_way][a_idx][a_off];
    end else if (fwd) begin
      ok_c   = 1'b1;
      data_c = bus.inst_read_data;
    end
  end

  assign bus.inst_ok       = ok_c;
  assign bus.inst_data     = data_c;
  assign bus.inst_read_req = req_q;
  assign bus.inst_addr_mmu = mmu_addr_q;

  // Miss FSM, valid/PLRU flops and registered MMU request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      vld        <= '0;
      for (int s = 0; s < SETS; s++)
        plru[s] <= '0;
      miss_addr  <= '0;
      victim     <= '0;
      cnt        <= '0;
      served     <= 1'b0;
      abort      <= 1'b0;
      inv_pend   <= 1'b0;
      req_q      <= 1'b0;
      mmu_addr_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (hit) begin
            plru[a_idx] <= plru_touch(plru[a_idx], hit_way);
          end else begin
            miss_addr  <= addr;
            victim     <= pick;
            req_q      <= 1'b1;
            mmu_addr_q <= {addr[31:OB], {OB{1'b0}}};
            state      <= REQ;
          end
        end
        REQ: begin
          if (bus.pc_changed)
            abort <= 1'b1;
          if (bus.inst_addr_ok) begin
            req_q      <= 1'b0;
            mmu_addr_q <= '0;
            cnt        <= '0;
            state      <= REFILL;
          end
        end
        REFILL: begin
          if (bus.pc_changed)
            abort <= 1'b1;
          if (fwd)
            served <= 1'b1;
          if (bus.mmu_valid) begin
            line_buf[cnt] <= bus.inst_read_data;
            cnt           <= cnt + 1'b1;
            if (bus.mmu_last)
              state <= FILL;
          end
        end
        FILL: begin
          plru[m_idx] <= plru_touch(plru[m_idx], victim);
          served      <= 1'b0;
          abort       <= 1'b0;
          inv_pend    <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (bus.inv_all) begin
        vld <= '0;
        if (state == REQ || state == REFILL)
          inv_pend <= 1'b1;
      end else if (state == FILL && !inv_pend) begin
        vld[victim][m_idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays: written only when a line retires.
  always_ff @(posedge clk) begin
    if (!rst && state == FILL) begin
      tag_mem[victim][m_idx]  <= m_tag;
      data_mem[victim][m_idx] <= line_buf;
    end
  end

endmodule

// File: tb/tb_instruction_cache_assoc.sv
// Directed bench: default 2-way cache and a 4-way/16-set/8-word build
// share one stimulus bus; dsel picks which outputs are checked.
module tb_instruction_cache_assoc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] addr = '0;
  logic        pc = 1'b0;
  logic        inv = 1'b0;
  logic        aok = 1'b0;
  logic [31:0] rd = '0;
  logic        mv = 1'b0;
  logic        ml = 1'b0;
  int          dsel = 0;

  instruction_cache_assoc_if b0 ();
  instruction_cache_assoc_if b1 ();

  assign b0.inst_addr      = addr;
  assign b0.pc_changed     = pc;
  assign b0.inv_all        = inv;
  assign b0.inst_addr_ok   = aok;
  assign b0.inst_read_data = rd;
  assign b0.mmu_valid      = mv;
  assign b0.mmu_last       = ml;
  assign b1.inst_addr      = addr;
  assign b1.pc_changed     = pc;
  assign b1.inv_all        = inv;
  assign b1.inst_addr_ok   = aok;
  assign b1.inst_read_data = rd;
  assign b1.mmu_valid      = mv;
  assign b1.mmu_last       = ml;

  instruction_cache_assoc u0 (
    .clk (clk),
    .rst (rst),
    .bus (b0.slave)
  );

  instruction_cache_assoc #(
    .WAYS(4), .SETS(16), .LINE_WORDS(8)
  ) u1 (
    .clk (clk),
    .rst (rst),
    .bus (b1.slave)
  );

  logic        ok_o;
  logic [31:0] data_o;
  logic        req_o;
  logic [31:0] mmu_o;
  assign ok_o   = (dsel == 1) ? b1.inst_ok       : b0.inst_ok;
  assign data_o = (dsel == 1) ? b1.inst_data     : b0.inst_data;
  assign req_o  = (dsel == 1) ? b1.inst_read_req : b0.inst_read_req;
  assign mmu_o  = (dsel == 1) ? b1.inst_addr_mmu : b0.inst_addr_mmu;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hit_chk(input logic [31:0] a,
                         input logic [31:0] exp);
    addr = a;
    #1;
    chk("hit_ok", 32'(ok_o), 32'd1);
    chk("hit_data", data_o, exp);
    tick();
    chk("hit_noreq", 32'(req_o), 32'd0);
  endtask

  // Miss on a, serve one burst of lw beats (base+i), checking
  // request address, forwarding beat/data and the FILL cycle.
  task automatic fetch_miss(input logic [31:0] a,
                            input logic [31:0] line,
                            input logic [31:0] base,
                            input int lw,
                            input int fwd,
                            input int pcb,
                            input logic [31:0] pca,
                            input int invb);
    int seen;
    int okc;
    logic [31:0] fd;
    seen = -1;
    okc  = 0;
    fd   = '0;
    addr = a;
    #1;
    chk("miss_ok", 32'(ok_o), 32'd0);
    chk("miss_noreq", 32'(req_o), 32'd0);
    tick();
    aok = 1'b1;
    #1;
    chk("req", 32'(req_o), 32'd1);
    chk("mmu_addr", mmu_o, line);
    tick();
    aok = 1'b0;
    for (int i = 0; i < lw; i++) begin
      mv = 1'b1;
      rd = base + 32'(i);
      ml = (i == lw - 1);
      if (i == pcb) begin
        pc   = 1'b1;
        addr = pca;
      end
      if (i == invb)
        inv = 1'b1;
      #1;
      if (ok_o === 1'b1) begin
        okc++;
        if (seen < 0) begin
          seen = i;
          fd   = data_o;
        end
      end
      tick();
      pc  = 1'b0;
      inv = 1'b0;
    end
    mv = 1'b0;
    ml = 1'b0;
    #1;
    chk("fill_ok", 32'(ok_o), 32'd0);
    chk("fill_noreq", 32'(req_o), 32'd0);
    tick();
    chk("fwd_cnt", 32'(okc), (fwd >= 0) ? 32'd1 : 32'd0);
    if (fwd >= 0) begin
      chk("fwd_beat", 32'(seen), 32'(fwd));
      chk("fwd_data", fd, base + 32'(fwd));
    end
  endtask

  initial begin
    int stable;
    dsel = 0;
    rst  = 1'b1;
    tick();
    tick();
    chk("rst_ok", 32'(ok_o), 32'd0);
    chk("rst_req", 32'(req_o), 32'd0);
    chk("rst_mmu", mmu_o, 32'd0);
    chk("rst_data", data_o, 32'd0);
    rst = 1'b0;

    // 1: first miss, critical word on beat 1
    fetch_miss(32'h1044, 32'h1040, 32'hA0, 16, 1, -1, 0, -1);
    hit_chk(32'h1044, 32'hA1);

    // 2: two ways in set 1, LRU eviction of tag 0x1
    fetch_miss(32'h3040, 32'h3040, 32'hB0, 16, 0, -1, 0, -1);
    hit_chk(32'h1040, 32'hA0);
    hit_chk(32'h3040, 32'hB0);
    fetch_miss(32'h2040, 32'h2040, 32'hC0, 16, 0, -1, 0, -1);
    hit_chk(32'h2040, 32'hC0);
    hit_chk(32'h3040, 32'hB0);
    fetch_miss(32'h1040, 32'h1040, 32'hA0, 16, 0, -1, 0, -1);
    hit_chk(32'h1044, 32'hA1);

    // 3: redirect mid-burst suppresses forwarding
    fetch_miss(32'h5008, 32'h5000, 32'hD0, 16, -1, 1,
               32'h1044, -1);
    hit_chk(32'h1044, 32'hA1);
    hit_chk(32'h5008, 32'hD2);

    // 4: invalidate during refill
    fetch_miss(32'h7000, 32'h7000, 32'hE0, 16, 0, -1, 0, 5);
    fetch_miss(32'h7000, 32'h7000, 32'hE0, 16, 0, -1, 0, -1);
    hit_chk(32'h7000, 32'hE0);
    fetch_miss(32'h3040, 32'h3040, 32'hB0, 16, 0, -1, 0, -1);
    hit_chk(32'h3040, 32'hB0);

    // 5: stalled request, then reset mid-refill
    addr = 32'h9000;
    #1;
    chk("t5_miss", 32'(ok_o), 32'd0);
    tick();
    stable = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (req_o === 1'b1 && mmu_o === 32'h9000)
        stable++;
      tick();
    end
    chk("req_hold", 32'(stable), 32'd10);
    aok = 1'b1;
    tick();
    aok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mv = 1'b1;
      rd = 32'h90 + 32'(i);
      tick();
    end
    mv   = 1'b0;
    rst  = 1'b1;
    addr = 32'h7000;
    tick();
    chk("rst5_ok", 32'(ok_o), 32'd0);
    chk("rst5_req", 32'(req_o), 32'd0);
    chk("rst5_mmu", mmu_o, 32'd0);
    chk("rst5_data", data_o, 32'd0);
    addr = 32'h3040;
    #1;
    chk("rst5_inval", 32'(ok_o), 32'd0);
    rst = 1'b0;
    tick();
    chk("rst5_newreq", 32'(req_o), 32'd1);
    chk("rst5_newaddr", mmu_o, 32'h3040);

    // 6: 4-way build, PLRU order and slicing
    rst  = 1'b1;
    dsel = 1;
    tick();
    rst = 1'b0;
    chk("r6_ok", 32'(ok_o), 32'd0);
    chk("r6_req", 32'(req_o), 32'd0);
    fetch_miss(32'h268, 32'h260, 32'h100, 8, 2, -1, 0, -1);
    fetch_miss(32'h468, 32'h460, 32'h200, 8, 2, -1, 0, -1);
    fetch_miss(32'h668, 32'h660, 32'h300, 8, 2, -1, 0, -1);
    fetch_miss(32'h868, 32'h860, 32'h400, 8, 2, -1, 0, -1);
    hit_chk(32'h268, 32'h102);
    hit_chk(32'h668, 32'h302);
    fetch_miss(32'hA68, 32'hA60, 32'h500, 8, 2, -1, 0, -1);
    hit_chk(32'h268, 32'h102);
    hit_chk(32'h668, 32'h302);
    hit_chk(32'h868, 32'h402);
    hit_chk(32'hA68, 32'h502);
    fetch_miss(32'h468, 32'h460, 32'h200, 8, 2, -1, 0, -1);
    fetch_miss(32'h668, 32'h660, 32'h300, 8, 2, -1, 0, -1);
    hit_chk(32'h868, 32'h402);
    hit_chk(32'hA68, 32'h502);
    hit_chk(32'h468, 32'h202);
    fetch_miss(32'h268, 32'h260, 32'h100, 8, 2, -1, 0, -1);
    fetch_miss(32'hFFFF_FFFC, 32'hFFFF_FFE0, 32'hF00, 8, 7,
               -1, 0, -1);
    hit_chk(32'hFFFF_FFFC, 32'hF07);
    hit_chk(32'hFFFF_FFE0, 32'hF00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
